fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage. It owns the program counter, drives the word address into the instruction memory, and receives the combinational instruction word back in the same cycle. It registers {inst, pc} into an IF/ID pipeline register for the decode stage. It handles stalls, taken-branch redirects with squash, and HALT detection, which drains the pipeline and then freezes fetch.

Parameters:
RESET_PC, 32'd0, PC value loaded on reset.
PC_STEP, 32'd1, PC increment per fetched instruction (word addressing).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
pc  output  32  fetch address to the instruction memory; the instruction returns combinationally on inst_in in the same cycle.
inst_in  input  `WIDTH  instruction word from the instruction memory at address pc.
stall  input  1  decode cannot accept the IF/ID register this cycle.
br_taken  input  1  taken branch resolved downstream; redirects fetch.
br_target  input  32  absolute target PC, valid when br_taken=1.
if_valid  output  1  IF/ID register holds a live instruction.
if_inst  output  `WIDTH  registered instruction.
if_pc  output  32  address of if_inst.
halted  output  1  HALT has been consumed; fetch is frozen.
fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- One clock, clk. Asynchronous active-high reset rst.
- Reset values:
  - pc=RESET_PC.
  - if_valid=0, if_inst=0, if_pc=0.
  - halted=0, fetch_count=0.
  - FSM=RUN.
- HALT detection: inst_in[`WIDTH-1:`WIDTH-5] == `HALT (opcode field from defines.vh).
- Per-edge priority: rst > br_taken > stall > FSM action.
- br_taken=1 (states RUN and DRAIN only):
  - pc<=br_target; if_valid<=0, which squashes the wrong-path fetch.
  - FSM<=RUN. The stall input is ignored that cycle.
  - fetch_count increments if if_valid=1 and stall=0, because the branch itself was accepted.
- stall=1 (and br_taken=0): pc, the IF/ID registers, the FSM and fetch_count all hold.
- FSM RUN, stall=0:
  - if_inst<=inst_in, if_pc<=pc, if_valid<=1.
  - fetch_count+=1 if if_valid was 1.
  - If inst_in is not HALT: pc<=pc+PC_STEP, wrapping modulo 2^32.
  - If inst_in is HALT: pc holds and FSM<=DRAIN.
- FSM DRAIN: the HALT sits in IF/ID and pc is frozen.
  - stall=0: HALT is accepted. if_valid<=0, fetch_count+=1, halted<=1, FSM<=HALTED.
  - br_taken: redirect per the rule above. This covers a HALT in the shadow of a branch.
- FSM HALTED: all registers hold, br_taken and stall are ignored, and if_valid=0. Only rst exits this state.
- Timing: fetch-to-IF/ID latency is 1 cycle. Steady-state throughput is 1 instruction/cycle. A redirect costs exactly 1 bubble cycle.
- pc is a register output and is never combinationally derived from br_target.
- Reset asserted mid-operation, including DRAIN and HALTED, returns all state to the reset values immediately, without waiting for a clock edge.

Test Plan:
- Reset release, memory holds MOV,MOV,MPY at 0..2, no stall → pc sequence 0,1,2,3 on successive edges; if_pc 0,1,2 with if_valid=1 from the first edge after reset.
- stall=1 for 3 cycles while if_pc=2 → pc stays 3, if_inst/if_pc stay unchanged, fetch_count frozen; resumes with if_pc=3 the cycle after stall drops.
- br_taken=1, br_target=2 while pc=6 → next edge pc=2, if_valid=0 for 1 cycle, then if_pc=2. A simultaneous stall=1 does not block the redirect.
- HALT word at address 6, program 0..6 straight-line → if_pc=6 holds HALT, pc frozen at 6, halted=1 one cycle after acceptance, fetch_count=7, and later br_taken pulses are ignored.
- HALT fetched into DRAIN, then br_taken=1, br_target=2 on the next edge → halted stays 0, FSM returns to RUN, pc=2.
- rst asserted asynchronously in DRAIN and again in HALTED → pc=0, if_valid=0, halted=0, fetch_count=0 with no clock edge required, and normal fetch from 0 after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, registers {inst, pc} into IF/ID,
// handles stall, taken-branch redirect with squash, and HALT drain/freeze.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef HALT
`define HALT 5'h1f
`endif

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic              clk,
  input  logic              rst,
  output logic [31:0]       pc,
  input  logic [`WIDTH-1:0] inst_in,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  output logic              if_valid,
  output logic [`WIDTH-1:0] if_inst,
  output logic [31:0]       if_pc,
  output logic              halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  state_t state;

  // opcode field of the word coming back from instruction memory
  logic is_halt;
  assign is_halt = (inst_in[`WIDTH-1 -: 5] == `HALT);

  // PC, IF/ID register, HALT state machine and accepted-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_inst     <= '0;
      if_pc       <= '0;
      halted      <= 1'b0;
      fetch_count <= '0;
      state       <= RUN;
    end else if (state != HALTED) begin
      if (br_taken) begin
        // redirect squashes the wrong-path word; the branch itself may retire
        pc       <= br_target;
        if_valid <= 1'b0;
        state    <= RUN;
        if (if_valid && !stall) fetch_count <= fetch_count + 32'd1;
      end else if (!stall) begin
        if (state == RUN) begin
          if_inst  <= inst_in;
          if_pc    <= pc;
          if_valid <= 1'b1;
          if (if_valid) fetch_count <= fetch_count + 32'd1;
          // HALT stays in IF/ID and fetch stops advancing
          if (is_halt) state <= DRAIN;
          else         pc    <= pc + PC_STEP;
        end else begin
          // DRAIN: decode takes the HALT, then fetch freezes for good
          if_valid    <= 1'b0;
          fetch_count <= fetch_count + 32'd1;
          halted      <= 1'b1;
          state       <= HALTED;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a transaction-level model.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef HALT
`define HALT 5'h1f
`endif

module tb_fetch_stage;
  localparam int W = `WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   pc;
  logic [W-1:0]  inst_in;
  logic          stall = 1'b0;
  logic          br_taken = 1'b0;
  logic [31:0]   br_target = '0;
  logic          if_valid;
  logic [W-1:0]  if_inst;
  logic [31:0]   if_pc;
  logic          halted;
  logic [31:0]   fetch_count;

  logic [W-1:0]  mem [64];
  assign inst_in = mem[pc[5:0]];

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc(pc), .inst_in(inst_in), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .if_valid(if_valid),
    .if_inst(if_inst), .if_pc(if_pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state: PC, IF/ID contents, halt pending / halted, accepted count
  logic [31:0]  m_pc, m_ipc, m_cnt;
  logic [W-1:0] m_inst;
  bit           m_valid, m_pending, m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] w;
    w = W'($urandom);
    if (w[W-1 -: 5] == `HALT) w[W-1] = ~w[W-1];
    return w;
  endfunction

  function automatic logic [W-1:0] mk(input logic [4:0] op);
    logic [W-1:0] w;
    w = rnd_word();
    w[W-1 -: 5] = op;
    return w;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_cnt = 0; m_inst = '0;
    m_valid = 0; m_pending = 0; m_halted = 0;
  endtask

  // one clock of the spec's rules, using the inputs held for this cycle
  task automatic model_step();
    logic [W-1:0] fw;
    fw = mem[m_pc[5:0]];
    if (m_halted) return;
    // decode accepts whatever live word it does not stall on
    if (m_valid && !stall) m_cnt = m_cnt + 1;
    if (br_taken) begin
      m_pc = br_target; m_valid = 0; m_pending = 0;
    end else if (stall) begin
      // hold
    end else if (m_pending) begin
      m_valid = 0; m_pending = 0; m_halted = 1;
    end else begin
      m_inst = fw; m_ipc = m_pc; m_valid = 1;
      if (fw[W-1 -: 5] == `HALT) m_pending = 1;
      else m_pc = m_pc + 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, m_valid});
    chk({tag, ".ipc"}, if_pc, m_ipc);
    chk({tag, ".inst"}, if_inst[31:0], m_inst[31:0]);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, ".cnt"}, fetch_count, m_cnt);
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    check_all(tag);
  endtask

  // asynchronous reset raised between edges, checked before any edge
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all(tag);
    stall = 0; br_taken = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 64; i++) mem[i] = rnd_word();
    mem[0] = mk(5'h01); mem[1] = mk(5'h01); mem[2] = mk(5'h05);
    mem[6] = mk(`HALT);
  endtask

  initial begin
    load_prog();
    model_reset();
    #12;
    check_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // straight-line fetch from 0
    cycle("seq0"); chk("seq0_pc", pc, 32'd1); chk("seq0_ipc", if_pc, 32'd0);
    cycle("seq1"); chk("seq1_pc", pc, 32'd2);
    cycle("seq2"); chk("seq2_pc", pc, 32'd3); chk("seq2_ipc", if_pc, 32'd2);

    // stall holds everything
    stall = 1;
    repeat (3) cycle("stall");
    chk("stall_pc", pc, 32'd3); chk("stall_ipc", if_pc, 32'd2); chk("stall_cnt", fetch_count, 32'd2);
    stall = 0;
    cycle("resume"); chk("resume_ipc", if_pc, 32'd3);
    cycle("run"); cycle("run");
    chk("pre_br_pc", pc, 32'd6);

    // redirect wins over a simultaneous stall
    br_taken = 1; br_target = 2; stall = 1;
    cycle("br"); chk("br_pc", pc, 32'd2); chk("br_valid", {31'd0, if_valid}, 32'd0);
    br_taken = 0; stall = 0;
    cycle("br_after"); chk("br_ipc", if_pc, 32'd2);

    // run until halted, then branches are ignored
    for (int i = 0; i < 40 && !m_halted; i++) cycle("tohalt");
    chk("halt_reached", {31'd0, halted}, 32'd1);
    br_taken = 1; br_target = 9;
    repeat (3) cycle("halted_br");
    br_taken = 0;
    async_reset("rst_halted");

    // straight-line 0..6 with HALT at 6
    for (int i = 0; i < 7; i++) cycle("line");
    chk("drain_pc", pc, 32'd6); chk("drain_ipc", if_pc, 32'd6);
    chk("drain_halted", {31'd0, halted}, 32'd0);
    cycle("accept");
    chk("line_halted", {31'd0, halted}, 32'd1); chk("line_cnt", fetch_count, 32'd7);
    async_reset("rst_line");

    // branch out of DRAIN cancels the halt
    for (int i = 0; i < 7; i++) cycle("line2");
    br_taken = 1; br_target = 2;
    cycle("drain_br");
    chk("drain_br_pc", pc, 32'd2); chk("drain_br_halted", {31'd0, halted}, 32'd0);
    br_taken = 0;
    cycle("post_drain_br"); chk("post_drain_ipc", if_pc, 32'd2);
    for (int i = 0; i < 4; i++) cycle("line3");
    async_reset("rst_drain");
    cycle("refetch"); chk("refetch_ipc", if_pc, 32'd0);

    // randomized traffic with sparse HALTs
    for (int i = 0; i < 64; i++) mem[i] = ($urandom % 12 == 0) ? mk(`HALT) : rnd_word();
    begin
      int hcnt = 0;
      for (int i = 0; i < 3000; i++) begin
        stall     = ($urandom % 4 == 0);
        br_taken  = ($urandom % 10 == 0);
        br_target = $urandom % 64;
        if (m_pending && $urandom % 3 == 0) async_reset("rnd_rst_drain");
        cycle("rnd");
        if (m_halted) hcnt++;
        if (hcnt > 3) begin
          hcnt = 0;
          async_reset("rnd_rst");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
